// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage of a simple in-order pipeline.
//
// Two-step fetch: the pre-IF step drives the instruction SRAM with nextpc.
// The IF step holds fs_valid, fs_pc and the instruction returned one cycle
// later. When decode stalls, the SRAM read data is only valid for the first
// stall cycle, so it is captured into a one-entry buffer. This keeps the
// instruction stable for a stall of any length.
//
// Ports
//   clk              clock, rising edge
//   reset            synchronous, active-high reset
//   ds_allowin       decode stage can accept an instruction this cycle
//   br_bus[32:0]     {br_taken, br_target} from decode
//   fs_to_ds_valid   fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus     {fs_pc, fs_inst}
//   inst_sram_en     SRAM read enable
//   inst_sram_we     SRAM byte write enables (always 0)
//   inst_sram_addr   SRAM fetch address (nextpc)
//   inst_sram_wdata  SRAM write data (always 0)
//   inst_sram_rdata  SRAM read data, valid one cycle after an enabled request
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q,    fs_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q,  inst_buf_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redirect;
  logic        fs_allowin;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // A branch only redirects once it actually leaves decode. Until then the
  // current IF contents are held (and suppressed as wrong-path).
  assign redirect   = br_taken && ds_allowin;
  assign nextpc     = redirect ? br_target : fs_pc_q + 32'd4;
  assign fs_allowin = !fs_valid_q || ds_allowin;

  assign inst_sram_en    = fs_allowin && !reset;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // The SRAM data is only valid in the cycle right after the request. After
  // that, the buffered copy is the instruction.
  assign fs_inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;

  assign fs_to_ds_valid = fs_valid_q && !br_taken && !reset;
  assign fs_to_ds_bus   = {fs_pc_q, fs_inst};

  always_comb begin
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (inst_sram_en) begin
      fs_valid_d  = 1'b1;
      fs_pc_d     = nextpc;
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !ds_allowin && !buf_valid_q) begin
      // This is the first stall cycle, so rdata still holds this pc's
      // instruction.
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= RESET_PC - 32'd4;
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else begin
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

endmodule
